// File: rtl/servo_hall_feedback.sv
// Hall-sensor position/period tracker: synchronizes and filters the hall code, then counts steps.
// Build option: define SERVO_HALL_FILTER_EN to insert the FILTER_LEN consecutive-sample filter.
//
// state    | meaning
// ST_INIT  | waiting for the first valid accepted hall code
// ST_TRACK | following the commutation sequence, counting steps and period
// ST_FAULT | invalid or skipped code seen; latched until fault_clear
module servo_hall_feedback #(
  parameter int FILTER_LEN   = 4,
  parameter int POS_WIDTH    = 32,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2:0]                     hall,
  input  logic                           pos_clear,
  input  logic                           fault_clear,
  output logic signed [POS_WIDTH-1:0]    position,
  output logic [PERIOD_WIDTH-1:0]        period,
  output logic                           direction,
  output logic                           step_valid,
  output logic                           stalled,
  output logic                           fault,
  output logic [2:0]                     hall_state
);

  typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;

  localparam logic [PERIOD_WIDTH-1:0]     PERIOD_MAX = '1;
  localparam logic [PERIOD_WIDTH-1:0]     CNT_ONE    = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [POS_WIDTH-1:0] POS_ONE    = {{(POS_WIDTH-1){1'b0}}, 1'b1};

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("FILTER_LEN must be in 1..15");
  end

  state_t                  state;
  logic [2:0]              hall_meta;
  logic [2:0]              hall_sync;
  logic [2:0]              code_acc;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic                    is_fwd;
  logic                    is_rev;

  always_ff @(posedge clk) begin
    if (reset) begin
      hall_meta <= 3'd0;
      hall_sync <= 3'd0;
    end else begin
      hall_meta <= hall;
      hall_sync <= hall_meta;
    end
  end

`ifdef SERVO_HALL_FILTER_EN
  localparam logic [3:0] FILT_THRESH = 4'(FILTER_LEN);

  logic [2:0] filt_last;
  logic [3:0] filt_cnt;
  logic [3:0] filt_cnt_nxt;
  logic [2:0] filt_code;

  // The current sample counts as one, so a code is accepted on its FILTER_LEN-th sample.
  always_comb begin
    filt_cnt_nxt = 4'd1;
    if (hall_sync == filt_last)
      filt_cnt_nxt = (filt_cnt == 4'd15) ? 4'd15 : filt_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_last <= 3'd0;
      filt_cnt  <= 4'd0;
      filt_code <= 3'd0;
    end else begin
      filt_last <= hall_sync;
      filt_cnt  <= filt_cnt_nxt;
      if (filt_cnt_nxt >= FILT_THRESH)
        filt_code <= hall_sync;
    end
  end

  assign code_acc = filt_code;
`else
  assign code_acc = hall_sync;
`endif

  function automatic logic [2:0] next_fwd(input logic [2:0] c);
    case (c)
      3'd1:    return 3'd3;
      3'd3:    return 3'd2;
      3'd2:    return 3'd6;
      3'd6:    return 3'd4;
      3'd4:    return 3'd5;
      3'd5:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] next_rev(input logic [2:0] c);
    case (c)
      3'd1:    return 3'd5;
      3'd5:    return 3'd4;
      3'd4:    return 3'd6;
      3'd6:    return 3'd2;
      3'd2:    return 3'd3;
      3'd3:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  assign is_fwd = (code_acc == next_fwd(hall_state));
  assign is_rev = (code_acc == next_rev(hall_state));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      position   <= '0;
      period     <= PERIOD_MAX;
      direction  <= 1'b1;
      step_valid <= 1'b0;
      stalled    <= 1'b1;
      fault      <= 1'b0;
      hall_state <= 3'd0;
      cnt        <= PERIOD_MAX;
    end else begin
      step_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          if (code_acc != 3'd0 && code_acc != 3'd7) begin
            hall_state <= code_acc;
            state      <= ST_TRACK;
            cnt        <= '0;
            stalled    <= 1'b0;
          end
        end
        ST_TRACK: begin
          if (code_acc == hall_state) begin
            if (cnt != PERIOD_MAX)
              cnt <= cnt + CNT_ONE;
            stalled <= (cnt >= PERIOD_MAX - CNT_ONE);
          end else if (is_fwd || is_rev) begin
            position   <= is_fwd ? position + POS_ONE : position - POS_ONE;
            direction  <= is_fwd;
            step_valid <= 1'b1;
            hall_state <= code_acc;
            period     <= (cnt == PERIOD_MAX) ? PERIOD_MAX : cnt + CNT_ONE;
            cnt        <= '0;
            stalled    <= 1'b0;
          end else begin
            // A clear arriving with the fault condition wins: straight back to INIT.
            stalled <= 1'b1;
            if (fault_clear) begin
              state <= ST_INIT;
            end else begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clear) begin
            fault <= 1'b0;
            state <= ST_INIT;
          end
        end
        default: state <= ST_INIT;
      endcase
      if (pos_clear)
        position <= '0;
    end
  end

endmodule

// File: tb/tb_servo_hall_feedback.sv
// Scoreboard bench for servo_hall_feedback: sample-history reference model, step queue, per-cycle output compare.
module tb_servo_hall_feedback;
  localparam int F    = 4;
  localparam int PW   = 6;
  localparam int PERW = 8;
  localparam int ONES = (1 << PERW) - 1;
`ifdef SERVO_HALL_FILTER_EN
  localparam int LAT  = 3 + F;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [2:0]           hall = 3'd0;
  logic                 pos_clear = 1'b0;
  logic                 fault_clear = 1'b0;
  logic signed [PW-1:0] position;
  logic [PERW-1:0]      period;
  logic                 direction;
  logic                 step_valid;
  logic                 stalled;
  logic                 fault;
  logic [2:0]           hall_state;

  servo_hall_feedback #(.FILTER_LEN(F), .POS_WIDTH(PW), .PERIOD_WIDTH(PERW)) dut (
    .clk(clk), .reset(reset), .hall(hall), .pos_clear(pos_clear), .fault_clear(fault_clear),
    .position(position), .period(period), .direction(direction), .step_valid(step_valid),
    .stalled(stalled), .fault(fault), .hall_state(hall_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nsteps = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  bit [2:0] seq [6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};

  function automatic bit [2:0] fwd(input bit [2:0] c);
    for (int i = 0; i < 6; i++) if (seq[i] == c) return seq[(i + 1) % 6];
    return 3'd0;
  endfunction

  function automatic bit [2:0] rev(input bit [2:0] c);
    for (int i = 0; i < 6; i++) if (seq[i] == c) return seq[(i + 5) % 6];
    return 3'd0;
  endfunction

  function automatic int sx(input int v);
    return ((v & ((1 << PW) - 1)) ^ (1 << (PW - 1))) - (1 << (PW - 1));
  endfunction

  // Reference model: hall history per cycle, acceptance by looking back over the sample window.
  typedef struct {int cyc; int pos; bit dir; int per;} exp_t;
  exp_t q[$];

  int       cyc = 0;
  bit [2:0] hist [64];
  bit [2:0] acc = 3'd0;
  int       mst = 0;
  int       mpos = 0;
  int       mcnt = ONES;
  int       mper = ONES;
  bit       mdir = 1'b1;
  bit [2:0] mcode = 3'd0;
  bit       mfault = 1'b0;

  initial for (int i = 0; i < 64; i++) hist[i] = 3'd0;

  always @(posedge clk) begin : model
    bit   all_eq;
    bit   stepped;
    exp_t e;
    cyc++;
    stepped = 1'b0;
    if (reset) begin
      mst = 0; mpos = 0; mcnt = ONES; mper = ONES; mdir = 1'b1;
      mcode = 3'd0; mfault = 1'b0; acc = 3'd0;
      hist[cyc & 63] = 3'd0;
    end else begin
      if (FILT) begin
        all_eq = 1'b1;
        for (int j = 1; j < F; j++)
          if (hist[(cyc - 3 - j) & 63] != hist[(cyc - 3) & 63]) all_eq = 1'b0;
        if (all_eq) acc = hist[(cyc - 3) & 63];
      end else begin
        acc = hist[(cyc - 2) & 63];
      end
      hist[cyc & 63] = hall;
      case (mst)
        0: if (acc >= 3'd1 && acc <= 3'd6) begin
             mcode = acc; mst = 1; mcnt = 0;
           end
        1: begin
             if (acc == mcode) begin
               if (mcnt < ONES) mcnt++;
             end else if (acc == fwd(mcode) || acc == rev(mcode)) begin
               mdir  = (acc == fwd(mcode));
               mpos  = mdir ? mpos + 1 : mpos - 1;
               mper  = (mcnt + 1 > ONES) ? ONES : mcnt + 1;
               mcnt  = 0;
               mcode = acc;
               stepped = 1'b1;
             end else if (fault_clear) begin
               mst = 0;
             end else begin
               mst = 2; mfault = 1'b1;
             end
           end
        default: if (fault_clear) begin
             mst = 0; mfault = 1'b0;
           end
      endcase
      if (pos_clear) mpos = 0;
      if (stepped) begin
        e.cyc = cyc; e.pos = mpos; e.dir = mdir; e.per = mper;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    chk("position", int'(position), sx(mpos));
    chk("period", int'(period), mper);
    chk("direction", int'(direction), int'(mdir));
    chk("fault", int'(fault), int'(mfault));
    chk("stalled", int'(stalled), int'(mst != 1 || mcnt == ONES));
    chk("hall_state", int'(hall_state), int'(mcode));
    if (step_valid) begin
      nsteps++;
      if (q.size() == 0) begin
        chk("spurious_step", 1, 0);
      end else begin
        e = q.pop_front();
        chk("step_cycle", cyc, e.cyc);
        chk("step_position", int'(position), sx(e.pos));
        chk("step_direction", int'(direction), int'(e.dir));
        chk("step_period", int'(period), e.per);
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk("missing_step_at_cycle", 0, e.cyc);
    end
  end

  task automatic hold(input bit [2:0] c, input int n);
    hall = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_position"}, int'(position), 0);
    chk({tag, "_period"}, int'(period), ONES);
    chk({tag, "_direction"}, int'(direction), 1);
    chk({tag, "_step_valid"}, int'(step_valid), 0);
    chk({tag, "_stalled"}, int'(stalled), 1);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_hall_state"}, int'(hall_state), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [2:0] cur;
    int n0, p0, lat, r, n;

    repeat (5) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    hold(3'd1, 20);
    chk("init_hall_state", int'(hall_state), 1);
    chk("init_position", int'(position), 0);
    chk("init_fault", int'(fault), 0);
    chk("init_steps", nsteps, 0);

    n0 = nsteps;
    cur = 3'd1;
    for (int i = 0; i < 6; i++) begin
      cur = fwd(cur);
      hold(cur, 100);
    end
    chk("fwd_steps", nsteps - n0, 6);
    chk("fwd_position", int'(position), 6);
    chk("fwd_direction", int'(direction), 1);
    chk("fwd_period", int'(period), 100);

    for (int i = 0; i < 3; i++) begin
      cur = rev(cur);
      hold(cur, 100);
    end
    chk("rev_position", int'(position), 3);
    chk("rev_direction", int'(direction), 0);

    cur = fwd(cur);
    hall = cur;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (step_valid) begin
        lat = k;
        break;
      end
    end
    chk("step_latency", lat, LAT);
    hold(cur, 20);

    p0 = int'(position);
    n0 = nsteps;
    hall = fwd(cur);
    repeat (3) @(posedge clk);
    #1;
    hold(cur, 20);
`ifdef SERVO_HALL_FILTER_EN
    chk("glitch_steps", nsteps - n0, 0);
    chk("glitch_position", int'(position), p0);
`endif

    p0 = int'(position);
    n0 = nsteps;
    hold(fwd(fwd(cur)), 20);
    chk("skip_fault", int'(fault), 1);
    chk("skip_stalled", int'(stalled), 1);
    hold(fwd(cur), 20);
    hold(cur, 20);
    chk("fault_ignored_steps", nsteps - n0, 0);
    chk("fault_ignored_position", int'(position), p0);
    chk("fault_held", int'(fault), 1);
    fault_clear = 1'b1;
    @(posedge clk);
    #1;
    fault_clear = 1'b0;
    chk("fault_cleared", int'(fault), 0);
    chk("fault_cleared_init", int'(stalled), 1);
    hold(cur, 20);
    chk("retrack_hall_state", int'(hall_state), int'(cur));
    chk("retrack_stalled", int'(stalled), 0);

    hall = 3'd7;
    repeat (LAT - 1) @(posedge clk);
    #1;
    fault_clear = 1'b1;
    @(posedge clk);
    #1;
    fault_clear = 1'b0;
    chk("clear_vs_fault_fault", int'(fault), 0);
    chk("clear_vs_fault_init", int'(stalled), 1);
    hold(3'd7, 10);
    chk("init_ignores_7", int'(fault), 0);
    hold(cur, 20);
    chk("retrack2_hall_state", int'(hall_state), int'(cur));

    cur = fwd(cur);
    hall = cur;
    repeat (LAT - 1) @(posedge clk);
    #1;
    pos_clear = 1'b1;
    @(posedge clk);
    #1;
    pos_clear = 1'b0;
    chk("posclr_step_valid", int'(step_valid), 1);
    chk("posclr_position", int'(position), 0);
    chk("posclr_direction", int'(direction), 1);
    hold(cur, 20);

    hold(cur, 300);
    chk("stall_flag", int'(stalled), 1);
    cur = fwd(cur);
    hold(cur, 20);
    chk("stall_released", int'(stalled), 0);
    chk("stall_period_sat", int'(period), ONES);

    pos_clear = 1'b1;
    @(posedge clk);
    #1;
    pos_clear = 1'b0;
    for (int i = 0; i < (1 << (PW - 1)) - 1; i++) begin
      cur = fwd(cur);
      hold(cur, LAT + 3);
    end
    chk("wrap_max_pos", int'(position), (1 << (PW - 1)) - 1);
    cur = fwd(cur);
    hold(cur, LAT + 3);
    chk("wrap_to_min", int'(position), -(1 << (PW - 1)));

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      n = $urandom_range(LAT + 2, 30);
      if (r < 4) begin
        cur = fwd(cur);
      end else if (r < 8) begin
        cur = rev(cur);
      end else if (r == 8) begin
        hall = fwd(cur);
        repeat (3) @(posedge clk);
        #1;
      end else begin
        pos_clear = 1'b1;
        @(posedge clk);
        #1;
        pos_clear = 1'b0;
      end
      hold(cur, n);
    end

    cur = fwd(cur);
    hall = cur;
    repeat (LAT - 1) @(posedge clk);
    #1;
    reset = 1'b1;
    pos_clear = 1'b1;
    fault_clear = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_values("midreset");
    reset = 1'b0;
    pos_clear = 1'b0;
    fault_clear = 1'b0;
    hold(cur, 20);
    chk("after_reset_hall_state", int'(hall_state), int'(cur));
    chk("after_reset_position", int'(position), 0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_hall_feedback.md
SERVO_HALL_FEEDBACK -- requirements
Module: servo_hall_feedback

Interface
REQ-001 Parameters: FILTER_LEN, default 4, consecutive identical samples required to accept a hall code (range 1..15).
REQ-002 Parameters: POS_WIDTH, default 32, signed position width; PERIOD_WIDTH, default 24, step-period counter width.
REQ-003 Ports: clk  in  1  core clock; all logic on rising edge.
REQ-004 Ports: reset  in  1  synchronous, active-high reset.
REQ-005 Ports: hall  in  3  raw asynchronous hall inputs {a,b,c}.
REQ-006 Ports: pos_clear  in  1  single-cycle pulse; zero position.
REQ-007 Ports: fault_clear  in  1  single-cycle pulse; leave FAULT state.
REQ-008 Ports: position  out  POS_WIDTH  signed step count.
REQ-009 Ports: period  out  PERIOD_WIDTH  clk cycles between last two accepted steps.
REQ-010 Ports: direction  out  1  1 = forward, 0 = reverse, from last step.
REQ-011 Ports: step_valid  out  1  one-cycle pulse per accepted step.
REQ-012 Ports: stalled  out  1  period counter saturated.
REQ-013 Ports: fault  out  1  invalid code or skipped step latched.
REQ-014 Ports: hall_state  out  3  current accepted hall code, for commutation logic.

Function
REQ-015 hall SHALL pass a 2-flop synchronizer before any other logic.
REQ-016 Filter: a synchronized code SHALL be accepted only after FILTER_LEN consecutive identical samples.
REQ-017 Forward sequence SHALL be 1->3->2->6->4->5->1; the reverse of that sequence is reverse.
REQ-018 States: INIT, TRACK, FAULT; reset enters INIT.
REQ-019 INIT: the first accepted code in 1..6 SHALL load hall_state and move to TRACK, with no step_valid and position unchanged.
REQ-020 TRACK: a forward neighbour SHALL cause position+1, direction=1, step_valid=1.
REQ-021 TRACK: a reverse neighbour SHALL cause position-1, direction=0, step_valid=1.
REQ-022 TRACK: code 0 or 7, or a non-adjacent valid code (skip), SHALL set fault=1 and move to FAULT with position unchanged.
REQ-023 FAULT: fault SHALL stay 1 and steps SHALL be ignored until fault_clear, which clears fault and moves to INIT.
REQ-024 Latency: a stable hall change SHALL produce step_valid/position update exactly 2+FILTER_LEN+1 cycles after the change reaches hall.
REQ-025 Period counter SHALL increment every cycle in TRACK and saturate at all-ones.
REQ-026 On a step, period SHALL load the counter value +1 and the counter SHALL restart at 0.
REQ-027 stalled SHALL be 1 while the counter is saturated or the state is not TRACK, and clear on the next accepted step.
REQ-028 Position SHALL wrap in two's complement, e.g. max positive +1 -> max negative.
REQ-029 pos_clear coincident with a step SHALL give position=0, while direction, period and step_valid still update.
REQ-030 fault_clear coincident with a new fault condition SHALL resolve as clear: the state goes to INIT and fault reads 0.

Reset
REQ-031 Reset SHALL set: position=0, period=all-ones, direction=1, step_valid=0, stalled=1, fault=0, hall_state=0, state INIT, filter and synchronizer flops 0.
REQ-032 Reset asserted mid-operation SHALL override every other input in that cycle.

Configuration
REQ-033 Macro SERVO_HALL_FILTER_EN defined: the FILTER_LEN filter of REQ-016 is instantiated.
REQ-034 Macro SERVO_HALL_FILTER_EN absent: the synchronizer output SHALL be accepted directly, latency becomes 3 cycles, and FILTER_LEN is ignored.

Verification
REQ-035 Reset, then hall=1 for 20 cycles -> TRACK, hall_state=1, position=0, no step_valid, fault=0.
REQ-036 Forward sequence 1,3,2,6,4,5,1 with each code held 100 cycles -> 6 step_valid pulses, position=6, direction=1, period=100.
REQ-037 From position 6, the reverse sequence for 3 steps -> position=3, direction=0.
REQ-038 hall 1->2 (skip) -> fault=1, FAULT state; steps then ignored; fault_clear pulse -> fault=0, INIT.
REQ-039 With the filter enabled, a 3-cycle glitch on a stable code (FILTER_LEN=4) -> no step_valid, position unchanged.
REQ-040 No hall change for 2^PERIOD_WIDTH cycles -> stalled=1; pos_clear on the same cycle as a step -> position=0 and step_valid=1.
